// File: rtl/q_sys_pio_pkg.sv
// Shared register map and edge-type encodings for the user input PIO.
package q_sys_pio_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 2;

   typedef enum logic [ADDR_W-1:0] {
      ADDR_DATA = 2'd0,
      ADDR_MASK = 2'd1,
      ADDR_RAW  = 2'd2,
      ADDR_EDGE = 2'd3
   } pio_addr_e;

   localparam int unsigned EDGE_RISE = 0;
   localparam int unsigned EDGE_FALL = 1;
   localparam int unsigned EDGE_ANY  = 2;

   // Edge qualifier: cur is the debounced level, prev its one-cycle-delayed copy.
   function automatic logic edge_detect(input int unsigned edge_type,
                                        input logic        cur,
                                        input logic        prev);
      logic rise;
      logic fall;
      rise = cur & ~prev;
      fall = ~cur & prev;
      if (edge_type == EDGE_RISE)      edge_detect = rise;
      else if (edge_type == EDGE_FALL) edge_detect = fall;
      else                             edge_detect = rise | fall;
   endfunction

endpackage

// File: rtl/q_sys_debounce_bit.sv
// One input channel: 2-flop synchronizer, debounce counter and edge detector.
module q_sys_debounce_bit
   import q_sys_pio_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned EDGE_TYPE       = EDGE_ANY
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din_i,
   output logic sync_o,
   output logic stable_o,
   output logic edge_c
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             stable_q;
   logic             stable_d;
   logic             stable_dly_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // A mismatch must persist for DEBOUNCE_CYCLES cycles before it is accepted.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_MAX) stable_d = sync2_q;
         else                  cnt_d    = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         stable_q     <= 1'b0;
         stable_dly_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         sync1_q      <= din_i;
         sync2_q      <= sync1_q;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         cnt_q        <= cnt_d;
      end
   end

   assign sync_o   = sync2_q;
   assign stable_o = stable_q;
   assign edge_c   = edge_detect(EDGE_TYPE, stable_q, stable_dly_q);

endmodule

// File: rtl/q_sys_user_input_pio.sv
// Avalon-MM debounced input PIO with per-channel edge capture and masked level interrupt.
module q_sys_user_input_pio
   import q_sys_pio_pkg::*;
#(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned EDGE_TYPE       = EDGE_ANY
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] readdata,
   input  logic [WIDTH-1:0]  in_port,
   output logic              irq
);

   logic [WIDTH-1:0]  sync_vec;
   logic [WIDTH-1:0]  stable_vec;
   logic [WIDTH-1:0]  edge_vec;
   logic [WIDTH-1:0]  irqmask_q;
   logic [WIDTH-1:0]  irqmask_d;
   logic [WIDTH-1:0]  edgecap_q;
   logic [WIDTH-1:0]  edgecap_d;
   logic [DATA_W-1:0] readdata_q;
   logic [DATA_W-1:0] readdata_d;
   logic              wr_c;
   pio_addr_e         addr_c;
   logic              unused_wdata_c;

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      q_sys_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .EDGE_TYPE       (EDGE_TYPE)
      ) u_bit (
         .clk      (clk),
         .reset_n  (reset_n),
         .din_i    (in_port[i]),
         .sync_o   (sync_vec[i]),
         .stable_o (stable_vec[i]),
         .edge_c   (edge_vec[i])
      );
   end

   assign wr_c           = chipselect & ~write_n;
   assign addr_c         = pio_addr_e'(address);
   assign unused_wdata_c = ^writedata;

   // A fresh edge wins over a simultaneous write-1-to-clear.
   always_comb begin
      irqmask_d  = irqmask_q;
      edgecap_d  = edgecap_q | edge_vec;
      readdata_d = '0;
      if (wr_c && addr_c == ADDR_MASK) irqmask_d = writedata[WIDTH-1:0];
      if (wr_c && addr_c == ADDR_EDGE) edgecap_d = (edgecap_q & ~writedata[WIDTH-1:0]) | edge_vec;
      case (addr_c)
         ADDR_DATA: readdata_d = DATA_W'(stable_vec);
         ADDR_MASK: readdata_d = DATA_W'(irqmask_q);
         ADDR_RAW:  readdata_d = DATA_W'(sync_vec);
         ADDR_EDGE: readdata_d = DATA_W'(edgecap_q);
         default:   readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irqmask_q  <= '0;
         edgecap_q  <= '0;
         readdata_q <= '0;
      end else begin
         irqmask_q  <= irqmask_d;
         edgecap_q  <= edgecap_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_q_sys_user_input_pio.sv
// Directed scoreboard bench: an any-edge and a rising-edge PIO driven with identical stimulus.
module tb_q_sys_user_input_pio;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [3:0]  in_port = 4'd0;
   logic [31:0] rd_any;
   logic [31:0] rd_rise;
   logic        irq_any;
   logic        irq_rise;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [31:0] exp_any;
      logic [31:0] exp_rise;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   q_sys_user_input_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut_any (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd_any),
      .in_port(in_port), .irq(irq_any)
   );

   q_sys_user_input_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut_rise (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd_rise),
      .in_port(in_port), .irq(irq_rise)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Push expectation, advance one clock, pop and compare both readdata ports.
   task automatic tick_chk(input string tag, input logic [31:0] ea, input logic [31:0] er);
      exp_t e;
      sb.push_back('{tag, ea, er});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({e.tag, "_any"}, rd_any, e.exp_any);
      check({e.tag, "_rise"}, rd_rise, e.exp_rise);
   endtask

   task automatic rd(input logic [1:0] a, input string tag,
                     input logic [31:0] ea, input logic [31:0] er);
      @(negedge clk);
      address = a;
      tick_chk(tag, ea, er);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
   endtask

   initial begin
      // Reset state
      #3 reset_n = 1'b0;
      #1;
      check("rst_rd_any", rd_any, 32'h0);
      check("rst_rd_rise", rd_rise, 32'h0);
      check("rst_irq_any", 32'(irq_any), 32'h0);
      check("rst_irq_rise", 32'(irq_rise), 32'h0);
      cycles(2);
      @(negedge clk);
      reset_n = 1'b1;
      cycles(2);

      // Accept latency: stable visible in readdata exactly 6 edges after first sample
      @(negedge clk);
      in_port = 4'h5;
      address = 2'd0;
      for (int k = 0; k <= 7; k++)
         tick_chk($sformatf("lat_k%0d", k), (k >= 6) ? 32'h5 : 32'h0, (k >= 6) ? 32'h5 : 32'h0);
      rd(2'd3, "lat_edge", 32'h5, 32'h5);
      rd(2'd2, "lat_raw", 32'h5, 32'h5);
      check("lat_irq", 32'(irq_any), 32'h0);

      // Return inputs low; only the any-edge instance captures the falls
      @(negedge clk);
      in_port = 4'h0;
      cycles(10);
      rd(2'd3, "fall_edge", 32'h5, 32'h5);
      wr(2'd3, 32'hF);
      rd(2'd3, "clr_edge", 32'h0, 32'h0);

      // Glitch rejection: bit0 sampled high for 3 cycles only
      @(negedge clk);
      in_port = 4'h1;
      address = 2'd2;
      for (int k = 0; k <= 7; k++) begin
         tick_chk($sformatf("glitch_raw_k%0d", k),
                  (k >= 2 && k <= 4) ? 32'h1 : 32'h0, (k >= 2 && k <= 4) ? 32'h1 : 32'h0);
         if (k == 2) in_port = 4'h0;
      end
      cycles(4);
      rd(2'd0, "glitch_stable", 32'h0, 32'h0);
      rd(2'd3, "glitch_edge", 32'h0, 32'h0);

      // Interrupt on accepted rise of bit0, cleared by write-1-to-clear
      wr(2'd1, 32'h1);
      rd(2'd1, "mask_rd", 32'h1, 32'h1);
      @(negedge clk);
      in_port = 4'h1;
      cycles(8);
      @(negedge clk);
      check("irq_set_any", 32'(irq_any), 32'h1);
      check("irq_set_rise", 32'(irq_rise), 32'h1);
      wr(2'd3, 32'h1);
      check("irq_clr_any", 32'(irq_any), 32'h0);
      check("irq_clr_rise", 32'(irq_rise), 32'h0);

      // Clear race: bit1 edge detected in the same cycle as its clear
      @(negedge clk);
      in_port = 4'h3;
      cycles(6);
      wr(2'd3, 32'h2);
      rd(2'd3, "race_edge", 32'h2, 32'h2);
      check("race_irq", 32'(irq_any), 32'h0);
      wr(2'd3, 32'h2);
      rd(2'd3, "race_clr_after", 32'h0, 32'h0);

      // Edge filter: bit3 rises and is accepted, then falls with bit3 unmasked
      @(negedge clk);
      in_port = 4'hB;
      cycles(10);
      rd(2'd3, "f_rise_edge", 32'h8, 32'h8);
      wr(2'd3, 32'hF);
      wr(2'd1, 32'h8);
      @(negedge clk);
      in_port = 4'h3;
      cycles(10);
      rd(2'd0, "f_stable", 32'h3, 32'h3);
      rd(2'd3, "f_fall_edge", 32'h8, 32'h0);
      check("f_irq_any", 32'(irq_any), 32'h1);
      check("f_irq_rise", 32'(irq_rise), 32'h0);

      // Reset mid-operation with bit2 debounce in progress
      @(negedge clk);
      in_port = 4'h7;
      address = 2'd3;
      cycles(3);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("mid_rst_rd_any", rd_any, 32'h0);
      check("mid_rst_rd_rise", rd_rise, 32'h0);
      check("mid_rst_irq_any", 32'(irq_any), 32'h0);
      check("mid_rst_irq_rise", 32'(irq_rise), 32'h0);
      in_port = 4'h0;
      cycles(3);
      @(negedge clk);
      reset_n = 1'b1;
      cycles(10);
      rd(2'd3, "post_rst_edge", 32'h0, 32'h0);
      rd(2'd0, "post_rst_stable", 32'h0, 32'h0);
      rd(2'd1, "post_rst_mask", 32'h0, 32'h0);
      check("post_rst_irq", 32'(irq_any), 32'h0);

      // Post-reset acceptance takes the full debounce latency again
      @(negedge clk);
      in_port = 4'h4;
      address = 2'd0;
      for (int k = 0; k <= 6; k++)
         tick_chk($sformatf("post_lat_k%0d", k), (k >= 6) ? 32'h4 : 32'h0, (k >= 6) ? 32'h4 : 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/q_sys_user_input_pio.md
Q_SYS_USER_INPUT_PIO -- requirements
Module: q_sys_user_input_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 4: input channel count, legal 1..32.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles before a channel change is accepted, legal 1..65535.
REQ-003 SHALL have parameter EDGE_TYPE, default 2: captured edge, 0 = rising, 1 = falling, 2 = any.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port address, input, 2 bits: Avalon-MM word address.
REQ-007 SHALL have port chipselect, input, 1 bit: slave select.
REQ-008 SHALL have port write_n, input, 1 bit: active-low write strobe, qualified by chipselect.
REQ-009 SHALL have port writedata, input, 32 bits: write data.
REQ-010 SHALL have port readdata, output, 32 bits: registered read data.
REQ-011 SHALL have port in_port, input, WIDTH bits: asynchronous external inputs.
REQ-012 SHALL have port irq, output, 1 bit: level interrupt, active high.

Function
REQ-013 SHALL pass each in_port bit through a 2-flop synchronizer; its output is sync[i].
REQ-014 SHALL keep per channel a debounced bit stable[i] and a counter cnt[i] sized to hold DEBOUNCE_CYCLES-1.
REQ-015 SHALL clear cnt[i] whenever sync[i] == stable[i].
REQ-016 SHALL, when sync[i] != stable[i], increment cnt[i], or load stable[i] <= sync[i] and clear cnt[i] if cnt[i] == DEBOUNCE_CYCLES-1.
REQ-017 SHALL discard any mismatch shorter than DEBOUNCE_CYCLES: no stable change, no edge.
REQ-018 SHALL detect an edge as stable[i] versus its one-cycle-delayed copy, filtered per EDGE_TYPE.
REQ-019 SHALL set edgecapture[i] on a detected edge.
REQ-020 SHALL clear each edgecapture bit written as 1 by a write to address 3; 0 bits are unaffected.
REQ-021 SHALL leave edgecapture[i] set when an edge and its clear occur in the same cycle.
REQ-022 SHALL map registers as: 0 = stable (read-only); 1 = irqmask (R/W, low WIDTH bits); 2 = sync raw value (read-only); 3 = edgecapture (read, write-1-to-clear).
REQ-023 SHALL ignore writes to addresses 0 and 2.
REQ-024 SHALL update readdata every clock from the register selected by address, zero-extended above WIDTH, independent of chipselect (one-cycle read latency).
REQ-025 SHALL drive irq = OR of (edgecapture & irqmask), decoded from registers with no added pipeline stage.
REQ-026 SHALL make a write to irqmask or edgecapture visible in readdata and irq starting from the cycle after the write.

Reset
REQ-027 SHALL asynchronously clear synchronizers, stable, delayed stable, cnt, irqmask, edgecapture and readdata to 0 while reset_n is low; irq is therefore 0.
REQ-028 SHALL abort any debounce in progress on reset, and SHALL NOT generate an edge from the reset release itself while in_port is 0.

Structure
REQ-029 SHALL take the register address constants (ADDR_DATA=0, ADDR_MASK=1, ADDR_RAW=2, ADDR_EDGE=3) and the EDGE_TYPE encodings from shared package q_sys_pio_pkg.
REQ-030 SHALL implement synchronizer, debounce counter and edge detect per channel in sub-module q_sys_debounce_bit (parameter DEBOUNCE_CYCLES, EDGE_TYPE), instantiated WIDTH times.

Verification
REQ-031 SHALL cover reset: assert reset_n low mid-operation -> readdata=0x0, irq=0, cnt cleared; after release with in_port=0, edgecapture stays 0.
REQ-032 SHALL cover accept latency: WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=2; in_port 0x0->0x5 held -> stable=0x5 exactly 2+4 cycles after first sampling edge; address 3 reads 0x5.
REQ-033 SHALL cover glitch rejection: bit0 high for 3 cycles -> address 2 shows 0x1 transiently, address 0 stays 0x0, edgecapture stays 0x0.
REQ-034 SHALL cover interrupt: irqmask=0x1, accepted rise on bit0 -> irq=1; write 0x1 to address 3 -> irq=0 the next cycle.
REQ-035 SHALL cover the clear race: clear 0x2 on address 3 in the same cycle bit1's edge is detected -> edgecapture bit1 remains 1.
REQ-036 SHALL cover edge filter: EDGE_TYPE=0, bit3 falls after being accepted high -> edgecapture bit3 stays 0, irq stays 0.
